// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM state codes,
// opcodes, ALUOp and ALUControl values, the Moore control bundle and small
// opcode helper functions.
package riscv_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTER = 4'd6;
    localparam state_t S_EXECUTEI = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Moore control bundle decoded from the current state
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       retire;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // True for the opcodes this controller knows how to sequence
    function automatic logic op_is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: legal = 1'b1;
            default:                                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Immediate format select derived straight from the opcode
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_STORE:  imm = 2'b01;
            OP_BRANCH: imm = 2'b10;
            OP_JAL:    imm = 2'b11;
            default:   imm = 2'b00;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps ALUOp plus instruction function bits to an ALU operation.
module mc_aludec
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Subtract only for R-type with funct7b5 set; I-type (op5=0) always adds
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (funct7b5 && op5) begin
                            alu_control = ALU_SUB;
                        end else begin
                            alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control unit: main FSM, Moore output decode, immediate
// select, illegal-opcode pulse and retired-instruction counter.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ALUOp_DBG,
    output logic [3:0]  State_DBG,
    output logic        IllegalOp,
    output logic        Retired,
    output logic [31:0] InstrCount
);

    state_t      state;
    state_t      next_state;
    ctrl_t       ctrl;
    logic [31:0] count;
    logic        legal_op;

    assign legal_op = op_is_legal(op);

    // State register; reset forces FETCH without waiting for a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; unused codes 11-15 fall back to FETCH
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                if ((op == OP_LOAD) || (op == OP_STORE)) begin
                    next_state = S_MEMADR;
                end else if (op == OP_RTYPE) begin
                    next_state = S_EXECUTER;
                end else if (op == OP_ITYPE) begin
                    next_state = S_EXECUTEI;
                end else if (op == OP_BRANCH) begin
                    next_state = S_BEQ;
                end else if (op == OP_JAL) begin
                    next_state = S_JAL;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEMADR: begin
                if (op == OP_LOAD) begin
                    next_state = S_MEMREAD;
                end else begin
                    next_state = S_MEMWRITE;
                end
            end
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = S_FETCH;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    // Moore output decode; every field not named for a state stays zero
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                ctrl.pc_update  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                ctrl.pc_update = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Retired-instruction counter; wraps naturally at 32 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (ctrl.retire) begin
            count <= count + 32'd1;
        end else begin
            count <= count;
        end
    end

    mc_aludec u_aludec (
        .alu_op      (ctrl.alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

    assign PCWrite    = ctrl.pc_update | (ctrl.branch & Zero);
    assign AdrSrc     = ctrl.adr_src;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign RegWrite   = ctrl.reg_write;
    assign ResultSrc  = ctrl.result_src;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ImmSrc     = imm_src_of(op);
    assign ALUOp_DBG  = ctrl.alu_op;
    assign State_DBG  = state;
    assign IllegalOp  = (state == S_DECODE) & ~legal_op;
    assign Retired    = ctrl.retire;
    assign InstrCount = count;

endmodule
